// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display blocks.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [3:0]  BLANK_CODE = 4'hF;
  localparam logic [3:0]  AN_OFF     = 4'b1111;

  // Digit k (k >= 1) is a leading zero when digits k..NUM_DIGITS-1 are all zero.
  function automatic logic lz_blanked(logic [4*NUM_DIGITS-1:0] digits, logic [1:0] k, logic lz);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(k) && digits[4*i +: 4] != 4'h0) begin
        upper_zero = 1'b0;
      end
    end
    return lz && (k != 2'd0) && upper_zero;
  endfunction

endpackage

// File: rtl/refresh_tick.sv
// Free-running prescaler: counts 0..REFRESH_DIV-1 and flags the last count.
module refresh_tick #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic                           tick,
  output logic [$clog2(REFRESH_DIV)-1:0] cnt
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntW'(REFRESH_DIV - 1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Four-digit BCD display scanner with frame-coherent shadow registers, guard
// interval and leading-zero blanking. All outputs are registered.
module bcd_display_scan
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  ABCD,
  output logic [3:0]  an,
  output logic        dp_n,
  output logic        blank
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);

  logic            tick;
  logic [CntW-1:0] cnt, cnt_nxt;

  logic [1:0]  idx_q, idx_d;
  logic [15:0] sh_digits_q, sh_digits_d;
  logic [3:0]  sh_dp_q, sh_dp_d;
  logic        sh_lz_q, sh_lz_d;

  logic [3:0] an_q, an_d;
  logic [3:0] abcd_q, abcd_d;
  logic       dp_n_q, dp_n_d;
  logic       blank_q, blank_d;
  logic       dark;

  refresh_tick #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_refresh_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick),
    .cnt  (cnt)
  );

  always_comb begin
    // Mirror the prescaler's next count so outputs track the upcoming slot position.
    cnt_nxt     = tick ? '0 : cnt + CntW'(1);
    idx_d       = tick ? idx_q + 2'd1 : idx_q;
    sh_digits_d = sh_digits_q;
    sh_dp_d     = sh_dp_q;
    sh_lz_d     = sh_lz_q;
    if (tick && idx_q == 2'd3) begin
      sh_digits_d = digits;
      sh_dp_d     = dp_in;
      sh_lz_d     = blank_lz;
    end

    dark = (32'(cnt_nxt) < GUARD) || lz_blanked(sh_digits_d, idx_d, sh_lz_d);

    an_d    = AN_OFF;
    abcd_d  = BLANK_CODE;
    dp_n_d  = 1'b1;
    blank_d = 1'b1;
    if (!dark) begin
      an_d    = ~(4'b0001 << idx_d);
      abcd_d  = sh_digits_d[{idx_d, 2'b00} +: 4];
      dp_n_d  = ~sh_dp_d[idx_d];
      blank_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q       <= 2'd0;
      sh_digits_q <= '0;
      sh_dp_q     <= '0;
      sh_lz_q     <= 1'b0;
      an_q        <= AN_OFF;
      abcd_q      <= 4'h0;
      dp_n_q      <= 1'b1;
      blank_q     <= 1'b1;
    end else begin
      idx_q       <= idx_d;
      sh_digits_q <= sh_digits_d;
      sh_dp_q     <= sh_dp_d;
      sh_lz_q     <= sh_lz_d;
      an_q        <= an_d;
      abcd_q      <= abcd_d;
      dp_n_q      <= dp_n_d;
      blank_q     <= blank_d;
    end
  end

  assign ABCD  = abcd_q;
  assign an    = an_q;
  assign dp_n  = dp_n_q;
  assign blank = blank_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan: a driver pushes model predictions per
// clock edge, a negedge monitor pops and compares against the DUT outputs.
module tb_bcd_display_scan;

  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FRAME = 4 * DIV;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] abcd;
    logic       dp_n;
    logic       blank;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  ABCD, an;
  logic        dp_n, blank;

  int vectors = 0;
  int miscompares = 0;

  exp_t exp_q[$];
  int   n_q[$];

  // Model state: edges since reset release and the frame-latched inputs.
  int          n = 0;
  logic [15:0] m_digits = 16'h0;
  logic [3:0]  m_dp = 4'h0;
  logic        m_lz = 1'b0;

  bcd_display_scan #(
    .REFRESH_DIV(DIV),
    .GUARD      (GUARD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .digits  (digits),
    .dp_in   (dp_in),
    .blank_lz(blank_lz),
    .ABCD    (ABCD),
    .an      (an),
    .dp_n    (dp_n),
    .blank   (blank)
  );

  always #5 clk = ~clk;

  function automatic exp_t reset_val();
    exp_t e;
    e.an = 4'b1111; e.abcd = 4'h0; e.dp_n = 1'b1; e.blank = 1'b1;
    return e;
  endfunction

  function automatic exp_t model(int cyc, logic [15:0] d, logic [3:0] dp, logic lz);
    exp_t        e;
    int          pos;
    int          slot;
    logic [15:0] upper;
    logic [3:0]  one;
    if (cyc == 0) return reset_val();
    pos   = cyc % DIV;
    slot  = (cyc / DIV) % 4;
    upper = d >> (4 * slot);
    one   = 4'b0001;
    if (pos < GUARD || (lz && slot != 0 && upper == 16'h0)) begin
      e.an = 4'b1111; e.abcd = 4'hF; e.dp_n = 1'b1; e.blank = 1'b1;
    end else begin
      e.an    = ~(one << slot);
      e.abcd  = upper[3:0];
      e.dp_n  = ~dp[slot];
      e.blank = 1'b0;
    end
    return e;
  endfunction

  task automatic check(string name, int cyc, exp_t want);
    exp_t got;
    got = '{an: an, abcd: ABCD, dp_n: dp_n, blank: blank};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s n=%0d got an=%b ABCD=%h dp_n=%b blank=%b want an=%b ABCD=%h dp_n=%b blank=%b",
               name, cyc, got.an, got.abcd, got.dp_n, got.blank,
               want.an, want.abcd, want.dp_n, want.blank);
    end
  endtask

  // One clock edge: advance the model with the inputs live at that edge.
  task automatic step();
    @(posedge clk);
    #1;
    n++;
    if (n % FRAME == 0) begin
      m_digits = digits;
      m_dp     = dp_in;
      m_lz     = blank_lz;
    end
    exp_q.push_back(model(n, m_digits, m_dp, m_lz));
    n_q.push_back(n);
  endtask

  task automatic run(int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic run_until_pos(int frame_pos);
    for (int i = 0; i < FRAME; i++) begin
      if (n % FRAME == frame_pos) break;
      step();
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    reset    = 1'b0;
    n        = 0;
    m_digits = 16'h0;
    m_dp     = 4'h0;
    m_lz     = 1'b0;
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] d;
    for (int k = 0; k < 4; k++) begin
      d[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    end
    return d;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check("scan", n_q.pop_front(), exp_q.pop_front());
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 0, reset_val());
    digits = 16'h1234;
    release_reset();
    #1;
    check("reset_release", 0, reset_val());

    // Basic scan; first frame shows zeros from the cleared shadows.
    run(3 * FRAME);

    // Leading-zero blanking.
    digits   = 16'h0050;
    blank_lz = 1'b1;
    run(2 * FRAME);
    digits = 16'h0000;
    run(2 * FRAME);

    // Frame coherence: change during slot 1.
    blank_lz = 1'b0;
    digits   = 16'h1111;
    run(FRAME);
    run_until_pos(DIV + 3);
    digits = 16'h9999;
    run(2 * FRAME);

    // Decimal point on digit 2.
    dp_in = 4'b0100;
    run(2 * FRAME);

    // Randomized traffic, including non-BCD nibbles and sparse leading zeros.
    for (int i = 0; i < 40 * FRAME; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        digits   = rand_digits();
        dp_in    = 4'($urandom_range(0, 15));
        blank_lz = 1'($urandom_range(0, 1));
      end
      step();
    end

    // Asynchronous reset in the middle of slot 2.
    digits   = 16'h8765;
    dp_in    = 4'b1010;
    blank_lz = 1'b0;
    run_until_pos(2 * DIV + 4);
    #6;
    reset = 1'b1;
    #1;
    check("async_reset", 0, reset_val());
    @(posedge clk);
    #1;
    check("reset_mid_hold", 0, reset_val());
    release_reset();
    run(3 * FRAME);

    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
